// File: rtl/mem_readback_checker.sv
// Read-side BRAM sweep checker: scans every address, compares against an address-derived
// pattern, and reports pass/fail, error count and first failing address. Optional: CHECK_SIGNATURE_EN.
module mem_readback_checker #(
   parameter int          WID_MEM      = 256,
   parameter int          DEPTH_MEM    = 128,
   parameter int          RD_LAT       = 1,
   parameter logic [31:0] PATTERN_SEED = 32'h0000_0000,
   parameter int          ERR_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [31:0]        raddr,
   input  logic [WID_MEM-1:0] dout,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_count,
   output logic               first_err_vld,
   output logic [31:0]        first_err_addr,
   output logic [31:0]        sig
);

   localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t          state;
   logic [AW-1:0]   addr_q;
   logic [2:0]      drain_cnt;
   logic [RD_LAT-1:0] tag_vld;
   logic [AW-1:0]   tag_addr [RD_LAT];
   logic            cmp_vld;
   logic [AW-1:0]   cmp_addr;
   logic            mismatch;
   logic            launch;

   // Replicate the 32-bit (addr ^ seed) word across the data width, LSB copy at [31:0].
   function automatic logic [WID_MEM-1:0] expected_word(input logic [AW-1:0] a);
      logic [31:0]        pat;
      logic [WID_MEM-1:0] w;
      pat = 32'(a) ^ PATTERN_SEED;
      for (int i = 0; i < WID_MEM; i++) w[i] = pat[i % 32];
      return w;
   endfunction

   assign raddr    = 32'(addr_q);
   assign cmp_vld  = tag_vld[RD_LAT-1];
   assign cmp_addr = tag_addr[RD_LAT-1];
   assign mismatch = (dout != expected_word(cmp_addr));
   assign launch   = start && (state == IDLE || state == DONE);

   // Response alignment: each issued address travels RD_LAT stages alongside the memory read.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) tag_vld[i] <= tag_vld[i-1];
         tag_vld[0] <= (state == SCAN);
      end
   end

   // NOTE: the address payload is qualified by tag_vld, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) tag_addr[i] <= tag_addr[i-1];
      tag_addr[0] <= addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         addr_q         <= '0;
         drain_cnt      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_vld  <= 1'b0;
         first_err_addr <= '0;
      end else begin
         if (cmp_vld && mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (!first_err_vld) begin
               first_err_vld  <= 1'b1;
               first_err_addr <= 32'(cmp_addr);
            end
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  err_count      <= '0;
                  first_err_vld  <= 1'b0;
                  first_err_addr <= '0;
                  addr_q         <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  state          <= SCAN;
               end
            end
            SCAN: begin
               if (addr_q == LAST_ADDR) begin
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else begin
                  addr_q <= addr_q + AW'(1);
               end
            end
            DRAIN: begin
               // One extra cycle lets the final compare land in err_count before pass is taken.
               if (drain_cnt == 3'(RD_LAT)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
                  state <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CHECK_SIGNATURE_EN
   localparam int NSL = (WID_MEM + 31) / 32;

   function automatic logic [31:0] fold_slices(input logic [WID_MEM-1:0] d);
      logic [NSL*32-1:0] padded;
      logic [31:0]       f;
      padded              = '0;
      padded[WID_MEM-1:0] = d;
      f                   = '0;
      for (int i = 0; i < NSL; i++) f = f ^ padded[i*32 +: 32];
      return f;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || launch) begin
         sig <= '0;
      end else if (cmp_vld) begin
         sig <= {sig[30:0], sig[31]} ^ fold_slices(dout);
      end
   end
`else
   assign sig = 32'h0;
`endif

endmodule
